// File: rtl/oled_spi_pkg.sv
// Shared types and constants for the OLED serial-link receiver.
package oled_spi_pkg;

  localparam logic        OLED_CMD  = 1'b0;
  localparam logic        OLED_DATA = 1'b1;
  localparam int unsigned OLED_BITS = 8;

  typedef struct packed {
    logic                 is_data;
    logic [OLED_BITS-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, with a configurable reset value.
module sync_2ff #(
  parameter int unsigned      WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] stage1;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stage1 <= RST_VAL;
      Q      <= RST_VAL;
    end else begin
      stage1 <= D;
      Q      <= stage1;
    end
  end

endmodule

// File: rtl/oled_spi_rx.sv
// Receive side of the OLED serial link: synchronise, deserialise MSB-first bytes,
// tag command/data and buffer them in a FIFO behind a valid/ready port.
module oled_spi_rx
  import oled_spi_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   SCLK,
  input  logic                   SDIN,
  input  logic                   DnC,
  input  logic                   nCS,
  output logic [OLED_BITS-1:0]   RxData,
  output logic                   RxIsData,
  output logic                   RxValid,
  input  logic                   RxReady,
  output logic [$clog2(DEPTH):0] Level,
  output logic                   Overflow,
  output logic                   FrameError,
  input  logic                   ClearErr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(OLED_BITS);

  logic [2:0] dataSync;
  logic       sclkSync, sdinSync, dncSync, ncsSync;
  logic       sclkPrev, ncsPrev;

  sync_2ff #(.WIDTH(3), .RST_VAL(3'b000)) uDataSync (
    .Clock (Clock),
    .Reset (Reset),
    .D     ({SCLK, SDIN, DnC}),
    .Q     (dataSync)
  );

  sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) uNcsSync (
    .Clock (Clock),
    .Reset (Reset),
    .D     (nCS),
    .Q     (ncsSync)
  );

  assign sclkSync = dataSync[2];
  assign sdinSync = dataSync[1];
  assign dncSync  = dataSync[0];

  logic                 sclkRise, ncsFall, ncsRise, bitRise, byteDone, frameSet;
  logic [CW-1:0]        bitCount;
  logic [OLED_BITS-2:0] shiftReg;
  rx_entry_t            pushEntry;

  assign sclkRise  = sclkSync & ~sclkPrev;
  assign ncsFall   = ~ncsSync & ncsPrev;
  assign ncsRise   = ncsSync & ~ncsPrev;
  assign bitRise   = sclkRise & ~ncsSync;
  assign byteDone  = bitRise && (bitCount == CW'(OLED_BITS - 1));
  assign frameSet  = ncsRise && (bitCount != '0);
  assign pushEntry = '{is_data: dncSync, data: {shiftReg, sdinSync}};

  // Shifter keeps only the first seven bits; the eighth goes straight into the push.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sclkPrev <= 1'b0;
      ncsPrev  <= 1'b1;
      bitCount <= '0;
      shiftReg <= '0;
    end else begin
      sclkPrev <= sclkSync;
      ncsPrev  <= ncsSync;
      if (ncsFall || ncsRise) begin
        bitCount <= '0;
        shiftReg <= '0;
      end else if (bitRise) begin
        shiftReg <= {shiftReg[OLED_BITS-3:0], sdinSync};
        bitCount <= bitCount + CW'(1);
      end
    end
  end

  rx_entry_t       mem [DEPTH];
  rx_entry_t       headNext;
  logic [PW-1:0]   wrPtr, rdPtr, wrNext, rdNext;
  logic            full, pop, pushOk, ovfSet;

  assign full     = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign pop      = RxValid && RxReady;
  assign pushOk   = byteDone && (!full || pop);
  assign ovfSet   = byteDone && full && !pop;
  assign wrNext   = wrPtr + PW'(pushOk);
  assign rdNext   = rdPtr + PW'(pop);
  // A push into a FIFO that is empty after this cycle's pop becomes the head directly.
  assign headNext = (pushOk && (rdNext == wrPtr)) ? pushEntry : mem[rdNext[AW-1:0]];

  always_ff @(posedge Clock) begin
    if (pushOk) begin
      mem[wrPtr[AW-1:0]] <= pushEntry;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      RxValid  <= 1'b0;
      Level    <= '0;
      RxData   <= '0;
      RxIsData <= 1'b0;
    end else begin
      wrPtr   <= wrNext;
      rdPtr   <= rdNext;
      RxValid <= (wrNext != rdNext);
      Level   <= wrNext - rdNext;
      if (pop || pushOk) begin
        RxData   <= headNext.data;
        RxIsData <= headNext.is_data;
      end
    end
  end

  // Sticky error flags; a new event in the same cycle beats the clear.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Overflow   <= 1'b0;
      FrameError <= 1'b0;
    end else begin
      if (ovfSet)        Overflow <= 1'b1;
      else if (ClearErr) Overflow <= 1'b0;
      if (frameSet)        FrameError <= 1'b1;
      else if (ClearErr)   FrameError <= 1'b0;
    end
  end

endmodule

// File: tb/tb_oled_spi_rx.sv
// Scoreboard bench for oled_spi_rx: drives serial frames and checks the FIFO stream and flags.
module tb_oled_spi_rx;
  import oled_spi_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          SCLK = 1'b0, SDIN = 1'b0, DnC = 1'b0, nCS = 1'b1;
  logic [7:0]    RxData;
  logic          RxIsData, RxValid;
  logic          RxReady = 1'b0;
  logic [LW-1:0] Level;
  logic          Overflow, FrameError;
  logic          ClearErr = 1'b0;

  int nCompared = 0;
  int nMismatch = 0;
  logic [8:0] expQ [$];

  oled_spi_rx #(.DEPTH(DEPTH)) dut (
    .Clock(Clock), .Reset(Reset), .SCLK(SCLK), .SDIN(SDIN), .DnC(DnC), .nCS(nCS),
    .RxData(RxData), .RxIsData(RxIsData), .RxValid(RxValid), .RxReady(RxReady),
    .Level(Level), .Overflow(Overflow), .FrameError(FrameError), .ClearErr(ClearErr)
  );

  always #5 Clock = ~Clock;

  // Scoreboard: compare every accepted head against the oldest expected entry.
  always @(negedge Clock) begin
    if (!Reset && RxValid && RxReady) begin
      nCompared++;
      if (expQ.size() == 0) begin
        nMismatch++;
        $display("FAIL scoreboard: unexpected entry got=%h", {RxIsData, RxData});
      end else begin
        logic [8:0] e;
        e = expQ.pop_front();
        if ({RxIsData, RxData} !== e) begin
          nMismatch++;
          $display("FAIL scoreboard: got=%h exp=%h", {RxIsData, RxData}, e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #2;
  endtask

  task automatic frameStart();
    nCS = 1'b0;
    tick(4);
  endtask

  task automatic frameEnd();
    tick(4);
    nCS = 1'b1;
    tick(6);
  endtask

  // Send the top n bits of b MSB-first; optionally hold RxReady for exactly the push cycle.
  task automatic sendBits(input logic [7:0] b, input int n, input logic dc, input logic popAtLast);
    DnC = dc;
    for (int i = 0; i < n; i++) begin
      SDIN = b[7-i];
      tick(4);
      SCLK = 1'b1;
      if (popAtLast && i == n - 1) begin
        tick(2);
        RxReady = 1'b1;
        tick(1);
        RxReady = 1'b0;
        tick(1);
      end else begin
        tick(4);
      end
      SCLK = 1'b0;
    end
    tick(4);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    RxReady = 1'b1;
    while (expQ.size() != 0 && n < 300) begin
      tick(1);
      n++;
    end
    RxReady = 1'b0;
    tick(2);
    nCompared++;
    if (expQ.size() != 0 || RxValid !== 1'b0 || Level !== LW'(0)) begin
      nMismatch++;
      $display("FAIL %s drain: pending=%0d RxValid=%b Level=%0d required pending=0 RxValid=0 Level=0",
               name, expQ.size(), RxValid, Level);
      expQ.delete();
    end
  endtask

  task automatic checkResetOutputs(input string name);
    nCompared++;
    if (RxValid !== 1'b0 || Level !== LW'(0) || Overflow !== 1'b0 || FrameError !== 1'b0 ||
        RxData !== 8'h00 || RxIsData !== 1'b0) begin
      nMismatch++;
      $display("FAIL %s: V=%b L=%0d O=%b F=%b D=%h T=%b required all zero",
               name, RxValid, Level, Overflow, FrameError, RxData, RxIsData);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick(3);
    checkResetOutputs("reset_state");
    Reset = 1'b0;
    tick(4);
    checkResetOutputs("after_release");
  endtask

  task automatic test_single_cmd();
    frameStart();
    sendBits(8'hAE, 8, OLED_CMD, 1'b0);
    expQ.push_back({OLED_CMD, 8'hAE});
    frameEnd();
    nCompared++;
    if (Level !== LW'(1) || RxValid !== 1'b1 || Overflow !== 1'b0 || FrameError !== 1'b0) begin
      nMismatch++;
      $display("FAIL single_cmd_status: L=%0d V=%b O=%b F=%b required L=1 V=1 O=0 F=0",
               Level, RxValid, Overflow, FrameError);
    end
    nCompared++;
    if (RxData !== 8'hAE || RxIsData !== OLED_CMD) begin
      nMismatch++;
      $display("FAIL single_cmd_head: got=%b_%h required 0_ae", RxIsData, RxData);
    end
    drain("single_cmd");
  endtask

  task automatic test_overflow_and_full_pushpop();
    frameStart();
    for (int i = 0; i < DEPTH + 2; i++) begin
      sendBits(8'(i), 8, OLED_DATA, 1'b0);
      if (i < DEPTH) expQ.push_back({OLED_DATA, 8'(i)});
    end
    nCompared++;
    if (Level !== LW'(DEPTH) || Overflow !== 1'b1 || FrameError !== 1'b0) begin
      nMismatch++;
      $display("FAIL overflow_status: L=%0d O=%b F=%b required L=8 O=1 F=0", Level, Overflow, FrameError);
    end
    sendBits(8'hA5, 8, OLED_DATA, 1'b1);
    expQ.push_back({OLED_DATA, 8'hA5});
    frameEnd();
    nCompared++;
    if (Level !== LW'(DEPTH) || Overflow !== 1'b1 || RxData !== 8'h01) begin
      nMismatch++;
      $display("FAIL full_pushpop: L=%0d O=%b head=%h required L=8 O=1 head=01", Level, Overflow, RxData);
    end
    drain("overflow");
    ClearErr = 1'b1;
    tick(1);
    ClearErr = 1'b0;
    tick(1);
    nCompared++;
    if (Overflow !== 1'b0) begin
      nMismatch++;
      $display("FAIL overflow_clear: O=%b required 0", Overflow);
    end
  endtask

  task automatic test_frame_error();
    frameStart();
    sendBits(8'hFF, 5, OLED_DATA, 1'b0);
    frameEnd();
    nCompared++;
    if (FrameError !== 1'b1 || Level !== LW'(0) || RxValid !== 1'b0) begin
      nMismatch++;
      $display("FAIL frame_error_set: F=%b L=%0d V=%b required F=1 L=0 V=0", FrameError, Level, RxValid);
    end
    frameStart();
    sendBits(8'h5A, 8, OLED_DATA, 1'b0);
    expQ.push_back({OLED_DATA, 8'h5A});
    frameEnd();
    nCompared++;
    if (FrameError !== 1'b1 || Level !== LW'(1)) begin
      nMismatch++;
      $display("FAIL frame_error_sticky: F=%b L=%0d required F=1 L=1", FrameError, Level);
    end
    drain("frame_error");
    ClearErr = 1'b1;
    tick(1);
    ClearErr = 1'b0;
    tick(1);
    nCompared++;
    if (FrameError !== 1'b0) begin
      nMismatch++;
      $display("FAIL frame_error_clear: F=%b required 0", FrameError);
    end
  endtask

  task automatic test_ncs_high();
    nCS = 1'b1;
    sendBits(8'hC3, 8, OLED_DATA, 1'b0);
    tick(6);
    nCompared++;
    if (Level !== LW'(0) || RxValid !== 1'b0 || Overflow !== 1'b0 || FrameError !== 1'b0) begin
      nMismatch++;
      $display("FAIL ncs_high_ignored: L=%0d V=%b O=%b F=%b required all zero",
               Level, RxValid, Overflow, FrameError);
    end
  endtask

  task automatic test_reset_midbyte();
    frameStart();
    sendBits(8'hF0, 4, OLED_DATA, 1'b0);
    Reset = 1'b1;
    tick(1);
    checkResetOutputs("reset_midbyte_asserted");
    nCS = 1'b1;
    tick(4);
    checkResetOutputs("reset_midbyte_held");
    Reset = 1'b0;
    tick(6);
    frameStart();
    sendBits(8'h3C, 8, OLED_CMD, 1'b0);
    expQ.push_back({OLED_CMD, 8'h3C});
    frameEnd();
    nCompared++;
    if (Level !== LW'(1) || FrameError !== 1'b0) begin
      nMismatch++;
      $display("FAIL reset_midbyte_recv: L=%0d F=%b required L=1 F=0", Level, FrameError);
    end
    drain("reset_midbyte");
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    logic       dc;
    RxReady = 1'b1;
    frameStart();
    for (int i = 0; i < 4; i++) begin
      b  = 8'($urandom_range(0, 255));
      dc = 1'(i & 1);
      expQ.push_back({dc, b});
      sendBits(b, 8, dc, 1'b0);
    end
    frameEnd();
    RxReady = 1'b0;
    drain("back_to_back");
  endtask

  initial begin
    test_reset();
    test_single_cmd();
    test_overflow_and_full_pushpop();
    test_frame_error();
    test_ncs_high();
    test_reset_midbyte();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/oled_spi_rx.md
# oled_spi_rx

Receive-side model of the cycle computer's write-only OLED serial link: SCLK, SDIN, DnC and nCS enter as asynchronous inputs. Each is synchronised to Clock. Each complete MSB-first byte is deserialised, tagged command or data from DnC, and buffered in a small FIFO behind a valid/ready port. Used on the FPGA test fixture and in SoC-level benches to check the byte stream the display driver emits, with overflow and truncated-byte detection.

## Interface
- DEPTH, 8 — FIFO entries; power of two, 2..64
- Clock  input  1  system clock; all state on rising edge
- Reset  input  1  asynchronous, active-high; clears all state
- SCLK  input  1  serial clock from the transmitter, asynchronous
- SDIN  input  1  serial data, valid on SCLK rising edge
- DnC  input  1  1 = data byte, 0 = command byte; sampled with 8th bit
- nCS  input  1  active-low frame select, asynchronous
- RxData  output  8  FIFO head byte
- RxIsData  output  1  FIFO head DnC tag
- RxValid  output  1  FIFO non-empty
- RxReady  input  1  consumer accepts head when RxValid && RxReady
- Level  output  $clog2(DEPTH)+1  entries held
- Overflow  output  1  sticky: a completed byte was dropped because the FIFO was full
- FrameError  output  1  sticky: nCS rose with 1..7 bits shifted
- ClearErr  input  1  synchronous clear of Overflow and FrameError

## Operation
- Synchronisation:
  - SCLK, SDIN, DnC and nCS each pass through two flops.
  - SCLK and nCS get a third flop for edge detection.
  - SCLK rise = sync & ~prev.
- Shifter:
  - Active only while synced nCS = 0.
  - On SCLK rise: shift reg ← {shift[6:0], SDIN}; bit count (3 bits) increments.
  - When count wraps 7→0, the byte is complete. Push {DnC, byte} that cycle, using the completed shift value including the current bit.
- nCS falling edge: bit count ← 0, shift ← 0.
- nCS rising edge:
  - Bit count ≠ 0: set FrameError, discard the partial byte, clear count.
  - Bit count = 0: no error.
- SCLK rises while nCS high are ignored.
- FIFO:
  - DEPTH entries of 9 bits; read/write pointers are $clog2(DEPTH)+1 bits, wrap-around via the MSB.
  - Push when full: entry dropped, Overflow ← 1, pointers unchanged.
  - Pop when RxValid && RxReady.
  - Push and pop in the same cycle: both take effect. This applies when full, where the push is accepted and no Overflow is set. It also applies when empty-with-push, where no pop occurs because RxValid is 0.
- Error flags: ClearErr clears the flags. If ClearErr coincides with a new error event, the set wins.
- Reset values: RxValid = 0, Level = 0, Overflow = 0, FrameError = 0, RxData = 0x00, RxIsData = 0. Shifter, count and pointers are cleared.
- Reset asserted mid-byte: the partial byte is lost. After release, reception resumes at the next nCS falling edge. A byte already in progress with nCS still low is received misaligned.

## Timing
- Input requirements:
  - SCLK high and low each ≥ 3 Clock periods.
  - nCS setup to the first SCLK rise ≥ 3 Clock periods; hold after the last rise ≥ 3.
  - SDIN and DnC stable ≥ 3 Clock periods around each SCLK rise.
- SCLK rise detected 3 Clock edges after the raw edge, cycle E. Shift and push occur at the end of E.
- RxValid rises in E+1, i.e. 4 Clock edges after the raw 8th SCLK rise.
- RxData and RxIsData are registered FIFO head outputs. The head is stable while RxValid && !RxReady.
- Pop in cycle P: the next entry appears, or RxValid drops, in P+1.
- Level updates one cycle after push/pop.
- Sustained throughput: one byte per 8 SCLK periods. One pop per Clock is possible.

## Structure
- Package oled_spi_pkg:
  - rx_entry_t packed struct {logic is_data; logic [7:0] data}
  - constants OLED_CMD = 1'b0, OLED_DATA = 1'b1, OLED_BITS = 8
- Sub-module sync_2ff: parameter WIDTH; two-flop synchroniser with async active-high Reset, reset value parameter RST_VAL. Instantiated with nCS RST_VAL = 1 and the others 0.
- FIFO is inline.

## Test plan
- Reset, then nCS low, send 0xAE with DnC = 0, nCS high → one entry {is_data = 0, data = 0xAE}, Level = 1, no flags.
- Hold RxReady = 0. Send DEPTH + 2 data bytes 0x00..0x09 (DEPTH = 8) → Level = 8, Overflow = 1, entries 0x00..0x07 in order, 0x08 and 0x09 absent.
- With RxReady = 1 at full, push and pop coincide → push accepted, Level stays 8, Overflow unchanged.
- Send 5 bits, then nCS high → FrameError = 1, no push. Next full byte 0x5A → 0x5A received aligned. ClearErr → flag 0.
- SCLK toggling 8 times with nCS high → no entries, no flags.
- Reset asserted after 4 bits of a byte, released, then 0x3C sent with a fresh nCS frame → only 0x3C received. All outputs 0 while Reset is asserted.
